// File: rtl/bht_update_sched.sv
// bht_update_sched: walks a clear over every BHT row, then drains resolved-branch updates through a small FIFO.
// Ports: clk_i / rst_ni (async, active-low); upd_valid_i, upd_pc_i, upd_taken_i, upd_ready_o (update intake);
// flush_i (restart the clear walk, drop queued updates); bht_stall_i (BHT write port busy);
// bht_upd_valid_o, bht_upd_pc_o, bht_upd_taken_o (update write); bht_clr_valid_o, bht_clr_idx_o (clear write);
// busy_o (clear walk in progress); drop_cnt_o (updates discarded while full).
// Macro BHT_SCHED_DROP_EN: keep upd_ready_o high in RUN and count updates discarded on a full FIFO.
module bht_update_sched #(
  parameter int VLEN       = 64,
  parameter int DEPTH      = 4,
  parameter int NR_ENTRIES = 1024,
  localparam int IDXW      = $clog2(NR_ENTRIES)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic            upd_ready_o,
  input  logic            flush_i,
  input  logic            bht_stall_i,
  output logic            bht_upd_valid_o,
  output logic [VLEN-1:0] bht_upd_pc_o,
  output logic            bht_upd_taken_o,
  output logic            bht_clr_valid_o,
  output logic [IDXW-1:0] bht_clr_idx_o,
  output logic            busy_o,
  output logic [15:0]     drop_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  logic            state;
  logic [IDXW-1:0] idx;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     cnt;
  logic [VLEN:0]   mem [DEPTH];
  logic            run, full, push, pop;
  assign run  = state == ST_RUN;
  // Fullness is taken from the start-of-cycle occupancy, so a same-cycle pop never makes room.
  assign full = cnt == (PW+1)'(DEPTH);
`ifdef BHT_SCHED_DROP_EN
  assign upd_ready_o = run;
`else
  assign upd_ready_o = run && !full;
`endif
  assign push            = upd_ready_o && upd_valid_i && !flush_i && !full;
  assign bht_upd_valid_o = run && cnt != '0;
  assign pop             = bht_upd_valid_o && !bht_stall_i;
  // Gate the head with valid so idle and reset outputs read as zero despite the unreset storage.
  assign {bht_upd_taken_o, bht_upd_pc_o} = bht_upd_valid_o ? mem[rd_ptr] : '0;
  assign bht_clr_valid_o = !run;
  assign bht_clr_idx_o   = idx;
  assign busy_o          = !run;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_CLEAR;
      idx    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      state  <= ST_CLEAR;
      idx    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (!run) begin
      if (!bht_stall_i) begin
        if (idx == IDXW'(NR_ENTRIES - 1)) state <= ST_RUN;
        else idx <= idx + IDXW'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {upd_taken_i, upd_pc_i};
  end
`ifdef BHT_SCHED_DROP_EN
  logic [15:0] drop_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt <= '0;
    else if (run && upd_valid_i && !flush_i && full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bht_update_sched.sv
// tb_bht_update_sched: random and directed stimulus against a queue-based reference model of bht_update_sched.
module tb_bht_update_sched;
  localparam int VLEN = 64;
  localparam int DEPTH = 4;
  localparam int NR = 16;
`ifdef BHT_SCHED_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            upd_valid_i;
  logic [VLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic            upd_ready_o;
  logic            flush_i;
  logic            bht_stall_i;
  logic            bht_upd_valid_o;
  logic [VLEN-1:0] bht_upd_pc_o;
  logic            bht_upd_taken_o;
  logic            bht_clr_valid_o;
  logic [3:0]      bht_clr_idx_o;
  logic            busy_o;
  logic [15:0]     drop_cnt_o;
  int checks = 0;
  int failures = 0;
  bht_update_sched #(.VLEN(VLEN), .DEPTH(DEPTH), .NR_ENTRIES(NR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_ready_o(upd_ready_o), .flush_i(flush_i),
    .bht_stall_i(bht_stall_i), .bht_upd_valid_o(bht_upd_valid_o), .bht_upd_pc_o(bht_upd_pc_o),
    .bht_upd_taken_o(bht_upd_taken_o), .bht_clr_valid_o(bht_clr_valid_o),
    .bht_clr_idx_o(bht_clr_idx_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  bit              m_clear;
  int              m_row;
  logic [VLEN:0]   m_q[$];
  int              m_drop;
  always @(negedge clk_i) begin : model
    logic [VLEN:0] h;
    bit ev, er, fl;
    if (!rst_ni) begin
      m_clear = 1'b1;
      m_row = 0;
      m_q.delete();
      m_drop = 0;
    end
    ev = !m_clear && m_q.size() > 0;
    er = !m_clear && (DROP || m_q.size() < DEPTH);
    h = ev ? m_q[0] : '0;
    chk("m_busy", busy_o, m_clear);
    chk("m_clr_valid", bht_clr_valid_o, m_clear);
    if (m_clear) chk("m_clr_idx", bht_clr_idx_o, m_row);
    chk("m_ready", upd_ready_o, er);
    chk("m_upd_valid", bht_upd_valid_o, ev);
    chk("m_upd_pc", bht_upd_pc_o, h[VLEN-1:0]);
    chk("m_upd_taken", bht_upd_taken_o, h[VLEN]);
    chk("m_drop_cnt", drop_cnt_o, m_drop);
    if (rst_ni) begin
      if (flush_i) begin
        m_clear = 1'b1;
        m_row = 0;
        m_q.delete();
      end else if (m_clear) begin
        if (!bht_stall_i) begin
          if (m_row == NR - 1) m_clear = 1'b0;
          else m_row++;
        end
      end else begin
        fl = m_q.size() >= DEPTH;
        if (ev && !bht_stall_i) void'(m_q.pop_front());
        if (upd_valid_i && er) begin
          if (!fl) m_q.push_back({upd_taken_i, upd_pc_i});
          else if (m_drop < 65535) m_drop++;
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wait_run(output int n);
    n = 0;
    while (busy_o && n < 100) begin
      cyc();
      n++;
    end
    chk("run_reached", busy_o, 1'b0);
  endtask
  initial begin
    int n;
    rst_ni = 1'b0;
    upd_valid_i = 1'b0;
    upd_pc_i = '0;
    upd_taken_i = 1'b0;
    flush_i = 1'b0;
    bht_stall_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_clr_valid", bht_clr_valid_o, 1'b1);
    chk("rst_clr_idx", bht_clr_idx_o, 0);
    chk("rst_ready", upd_ready_o, 1'b0);
    chk("rst_upd_valid", bht_upd_valid_o, 1'b0);
    rst_ni = 1'b1;
    for (int i = 0; i < NR; i++) begin
      chk("walk_idx", bht_clr_idx_o, i);
      chk("walk_busy", busy_o, 1'b1);
      cyc();
    end
    chk("walk_busy_fall", busy_o, 1'b0);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("restart_idx", bht_clr_idx_o, 0);
    repeat (5) cyc();
    chk("stall_idx_pre", bht_clr_idx_o, 5);
    bht_stall_i = 1'b1;
    repeat (3) begin
      cyc();
      chk("stall_idx_hold", bht_clr_idx_o, 5);
    end
    bht_stall_i = 1'b0;
    wait_run(n);
    chk("stall_walk_len", n, 11);
    upd_valid_i = 1'b1;
    upd_pc_i = 64'h100;
    upd_taken_i = 1'b1;
    cyc();
    upd_pc_i = 64'h200;
    upd_taken_i = 1'b0;
    chk("ord_v0", bht_upd_valid_o, 1'b1);
    chk("ord_pc0", bht_upd_pc_o, 64'h100);
    chk("ord_tk0", bht_upd_taken_o, 1'b1);
    cyc();
    upd_valid_i = 1'b0;
    chk("ord_pc1", bht_upd_pc_o, 64'h200);
    chk("ord_tk1", bht_upd_taken_o, 1'b0);
    cyc();
    chk("ord_empty", bht_upd_valid_o, 1'b0);
    bht_stall_i = 1'b1;
    upd_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      upd_pc_i = 64'h1000 + 64'(i * 16);
      upd_taken_i = i[0];
      chk("fill_ready", upd_ready_o, 1'b1);
      cyc();
    end
    upd_pc_i = 64'h2000;
    if (DROP) begin
      chk("full_ready_drop", upd_ready_o, 1'b1);
      cyc();
      upd_pc_i = 64'h3000;
      cyc();
      upd_valid_i = 1'b0;
      chk("drop_cnt2", drop_cnt_o, 2);
    end else begin
      chk("full_ready", upd_ready_o, 1'b0);
      cyc();
      upd_valid_i = 1'b0;
      chk("drop_cnt0", drop_cnt_o, 0);
    end
    bht_stall_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", bht_upd_valid_o, 1'b1);
      chk("drain_pc", bht_upd_pc_o, 64'h1000 + 64'(i * 16));
      cyc();
    end
    chk("drain_empty", bht_upd_valid_o, 1'b0);
    bht_stall_i = 1'b1;
    upd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_pc_i = 64'h4000 + 64'(i);
      cyc();
    end
    upd_valid_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    bht_stall_i = 1'b0;
    chk("flush_valid", bht_upd_valid_o, 1'b0);
    chk("flush_busy", busy_o, 1'b1);
    chk("flush_idx", bht_clr_idx_o, 0);
    wait_run(n);
    chk("flush_no_write", bht_upd_valid_o, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (1000) begin
        upd_valid_i = 1'($urandom);
        upd_pc_i = {$urandom, $urandom};
        upd_taken_i = 1'($urandom);
        bht_stall_i = p == 0 ? ($urandom_range(3) == 0) : p == 1 ? ($urandom_range(3) != 0) : 1'($urandom);
        flush_i = $urandom_range(299) == 0;
        cyc();
      end
    end
    upd_valid_i = 1'b0;
    flush_i = 1'b0;
    bht_stall_i = 1'b0;
    wait_run(n);
    repeat (DEPTH + 1) cyc();
    bht_stall_i = 1'b1;
    upd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_pc_i = 64'h5000 + 64'(i);
      upd_taken_i = 1'b1;
      cyc();
    end
    upd_valid_i = 1'b0;
    bht_stall_i = 1'b0;
    cyc();
    chk("mid_drain_valid", bht_upd_valid_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_clr_valid", bht_clr_valid_o, 1'b1);
    chk("arst_clr_idx", bht_clr_idx_o, 0);
    chk("arst_busy", busy_o, 1'b1);
    chk("arst_ready", upd_ready_o, 1'b0);
    chk("arst_upd_valid", bht_upd_valid_o, 1'b0);
    chk("arst_upd_pc", bht_upd_pc_o, 0);
    chk("arst_upd_taken", bht_upd_taken_o, 1'b0);
    chk("arst_drop", drop_cnt_o, 0);
    cyc();
    rst_ni = 1'b1;
    chk("arst_walk0", bht_clr_idx_o, 0);
    cyc();
    chk("arst_walk1", bht_clr_idx_o, 1);
    wait_run(n);
    chk("arst_walk_len", n, 15);
    chk("arst_empty", bht_upd_valid_o, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
